// File: rtl/reset_sequencer_pkg.sv
// Shared types and constants for the reset sequencer.
package reset_sequencer_pkg;

    // Sequencer states, in release order.
    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        REL_BUS = 2'd1,
        REL_CPU = 2'd2,
        RUN     = 2'd3
    } seq_state_t;

    // Bit positions inside RESET_CAUSE.
    localparam int CAUSE_POR = 0;
    localparam int CAUSE_EXT = 1;
    localparam int CAUSE_WDT = 2;
    localparam int CAUSE_SW  = 3;

    localparam int CAUSE_W = 4;

endpackage

// File: rtl/ext_pin_sync.sv
// Multi-flop synchronizer for the external active-low reset pin.
// A parallel valid chain tracks how far the post-reset 1s have propagated,
// so the cleared data flops are not mistaken for a real pin assertion.
module ext_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pin_n,
    output logic o_sync_n,
    output logic o_valid
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_vld;

    // Shift the pin level and a constant 1 through matching flop chains.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_vld  <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin_n};
            r_vld  <= {r_vld[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign o_sync_n = r_sync[SYNC_STAGES-1];
    assign o_valid  = r_vld[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: stretches any reset request, then releases the bus
// fabric first and the CPU a programmable number of cycles later.
// Also records sticky reset-cause flags.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int STRETCH_CYCLES = 16,
    parameter int STAGE_GAP      = 4,
    parameter int SYNC_STAGES    = 2
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               EXT_RESET_N,
    input  logic               WDT_RESET_REQ,
    input  logic               SYSRESETREQ,
    input  logic               CAUSE_CLR,
    output logic               BUS_RESET_N,
    output logic               CPU_RESET_N,
    output logic [CAUSE_W-1:0] RESET_CAUSE,
    output logic               SEQ_BUSY
);

    localparam logic [7:0] STRETCH_LD = 8'(STRETCH_CYCLES - 1);
    localparam logic [7:0] GAP_LD     = 8'(STAGE_GAP - 1);

    seq_state_t         r_state;
    seq_state_t         w_nxt_state;
    logic [7:0]         r_cnt;
    logic [7:0]         w_nxt_cnt;
    logic               r_bus_n;
    logic               r_cpu_n;
    logic               r_busy;
    logic [CAUSE_W-1:0] r_cause;
    logic [CAUSE_W-1:0] w_cause_set;

    logic               w_ext_n_s;
    logic               w_ext_vld;
    logic               w_ext_req;
    logic               w_req;

    ext_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ext_sync (
        .i_clk    (CLK),
        .i_rst_n  (RESET),
        .i_pin_n  (EXT_RESET_N),
        .o_sync_n (w_ext_n_s),
        .o_valid  (w_ext_vld)
    );

    // The pin only counts once the synchronizer has been primed after POR.
    assign w_ext_req = w_ext_vld & ~w_ext_n_s;
    assign w_req     = w_ext_req | WDT_RESET_REQ | SYSRESETREQ;

    // Next-state and counter logic; any request restarts the stretch.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        if (w_req) begin
            w_nxt_state = ASSERT;
            w_nxt_cnt   = STRETCH_LD;
        end else begin
            case (r_state)
                ASSERT: begin
                    if (r_cnt == 8'd0) begin
                        w_nxt_state = REL_BUS;
                        w_nxt_cnt   = GAP_LD;
                    end else begin
                        w_nxt_cnt = r_cnt - 8'd1;
                    end
                end
                REL_BUS: begin
                    if (r_cnt == 8'd0) begin
                        w_nxt_state = REL_CPU;
                    end else begin
                        w_nxt_cnt = r_cnt - 8'd1;
                    end
                end
                REL_CPU: begin
                    w_nxt_state = RUN;
                end
                RUN: begin
                    w_nxt_state = RUN;
                end
                default: begin
                    w_nxt_state = ASSERT;
                    w_nxt_cnt   = STRETCH_LD;
                end
            endcase
        end
    end

    // State, counter and registered outputs decoded from the next state,
    // so the reset outputs come straight off flops.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= ASSERT;
            r_cnt   <= STRETCH_LD;
            r_bus_n <= 1'b0;
            r_cpu_n <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_bus_n <= (w_nxt_state != ASSERT);
            r_cpu_n <= (w_nxt_state == REL_CPU) || (w_nxt_state == RUN);
            r_busy  <= (w_nxt_state != RUN);
        end
    end

    // Per-source set vector for the sticky cause flags.
    always_comb begin
        w_cause_set            = '0;
        w_cause_set[CAUSE_EXT] = w_ext_req;
        w_cause_set[CAUSE_WDT] = WDT_RESET_REQ;
        w_cause_set[CAUSE_SW]  = SYSRESETREQ;
    end

    // Sticky cause flags: a set in the same cycle as a clear wins.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_cause <= CAUSE_W'(1) << CAUSE_POR;
        end else begin
            r_cause <= (CAUSE_CLR ? '0 : r_cause) | w_cause_set;
        end
    end

    assign BUS_RESET_N = r_bus_n;
    assign CPU_RESET_N = r_cpu_n;
    assign SEQ_BUSY    = r_busy;
    assign RESET_CAUSE = r_cause;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with default parameters.
module tb_reset_sequencer;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       EXT_RESET_N;
    logic       WDT_RESET_REQ;
    logic       SYSRESETREQ;
    logic       CAUSE_CLR;
    logic       BUS_RESET_N;
    logic       CPU_RESET_N;
    logic [3:0] RESET_CAUSE;
    logic       SEQ_BUSY;

    int n_chk  = 0;
    int n_fail = 0;

    reset_sequencer dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .EXT_RESET_N   (EXT_RESET_N),
        .WDT_RESET_REQ (WDT_RESET_REQ),
        .SYSRESETREQ   (SYSRESETREQ),
        .CAUSE_CLR     (CAUSE_CLR),
        .BUS_RESET_N   (BUS_RESET_N),
        .CPU_RESET_N   (CPU_RESET_N),
        .RESET_CAUSE   (RESET_CAUSE),
        .SEQ_BUSY      (SEQ_BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b0; EXT_RESET_N = 1'b1; WDT_RESET_REQ = 1'b0;
        SYSRESETREQ = 1'b0; CAUSE_CLR = 1'b0;

        // Held in reset
        step(3);
        chk("rst_bus", BUS_RESET_N, 1'b0);
        chk("rst_cpu", CPU_RESET_N, 1'b0);
        chk("rst_cause", RESET_CAUSE, 4'b0001);
        chk("rst_busy", SEQ_BUSY, 1'b1);

        // POR release sequence
        RESET = 1'b1;
        step(15); chk("por_bus_e15", BUS_RESET_N, 1'b0);
        step(1);  chk("por_bus_e16", BUS_RESET_N, 1'b1);
                  chk("por_cpu_e16", CPU_RESET_N, 1'b0);
        step(3);  chk("por_cpu_e19", CPU_RESET_N, 1'b0);
        step(1);  chk("por_cpu_e20", CPU_RESET_N, 1'b1);
                  chk("por_busy_e20", SEQ_BUSY, 1'b1);
        step(1);  chk("por_busy_e21", SEQ_BUSY, 1'b0);
                  chk("por_cause", RESET_CAUSE, 4'b0001);

        // Watchdog pulse in RUN
        WDT_RESET_REQ = 1'b1; step(1); WDT_RESET_REQ = 1'b0;
        chk("wdt_bus_e0", BUS_RESET_N, 1'b0);
        chk("wdt_cpu_e0", CPU_RESET_N, 1'b0);
        chk("wdt_cause", RESET_CAUSE, 4'b0101);
        step(15); chk("wdt_bus_e15", BUS_RESET_N, 1'b0);
        step(1);  chk("wdt_bus_e16", BUS_RESET_N, 1'b1);
                  chk("wdt_cpu_e16", CPU_RESET_N, 1'b0);
        step(3);  chk("wdt_cpu_e19", CPU_RESET_N, 1'b0);
        step(1);  chk("wdt_cpu_e20", CPU_RESET_N, 1'b1);
        step(1);  chk("wdt_busy_e21", SEQ_BUSY, 1'b0);

        // Software request held 10 cycles
        SYSRESETREQ = 1'b1; step(10); SYSRESETREQ = 1'b0;
        chk("sw_bus_last", BUS_RESET_N, 1'b0);
        chk("sw_cause", RESET_CAUSE, 4'b1101);
        step(15); chk("sw_bus_e15", BUS_RESET_N, 1'b0);
        step(1);  chk("sw_bus_e16", BUS_RESET_N, 1'b1);
        step(5);  chk("sw_busy_run", SEQ_BUSY, 1'b0);

        // Cause clear alone leaves the sequencer running
        CAUSE_CLR = 1'b1; step(1); CAUSE_CLR = 1'b0;
        chk("clr_cause", RESET_CAUSE, 4'b0000);
        chk("clr_busy", SEQ_BUSY, 1'b0);

        // External pin pulled low during REL_BUS
        SYSRESETREQ = 1'b1; step(1); SYSRESETREQ = 1'b0;
        chk("ext_pre_cause", RESET_CAUSE, 4'b1000);
        step(16); chk("ext_relbus_bus", BUS_RESET_N, 1'b1);
        EXT_RESET_N = 1'b0;
        step(1); chk("ext_cpu_e1", CPU_RESET_N, 1'b0);
        step(1); chk("ext_cpu_e2", CPU_RESET_N, 1'b0);
        step(1); chk("ext_bus_e3", BUS_RESET_N, 1'b0);
                 chk("ext_cpu_e3", CPU_RESET_N, 1'b0);
        EXT_RESET_N = 1'b1;
        chk("ext_cause", RESET_CAUSE, 4'b1010);
        step(40);
        chk("ext_done_busy", SEQ_BUSY, 1'b0);
        chk("ext_done_cpu", CPU_RESET_N, 1'b1);

        // Asynchronous RESET during REL_CPU
        SYSRESETREQ = 1'b1; step(1); SYSRESETREQ = 1'b0;
        step(20);
        chk("relcpu_cpu", CPU_RESET_N, 1'b1);
        chk("relcpu_busy", SEQ_BUSY, 1'b1);
        #1 RESET = 1'b0;
        #1;
        chk("arst_bus", BUS_RESET_N, 1'b0);
        chk("arst_cpu", CPU_RESET_N, 1'b0);
        chk("arst_cause", RESET_CAUSE, 4'b0001);
        chk("arst_busy", SEQ_BUSY, 1'b1);
        #1 RESET = 1'b1;
        step(15); chk("rep_bus_e15", BUS_RESET_N, 1'b0);
        step(1);  chk("rep_bus_e16", BUS_RESET_N, 1'b1);
        step(3);  chk("rep_cpu_e19", CPU_RESET_N, 1'b0);
        step(1);  chk("rep_cpu_e20", CPU_RESET_N, 1'b1);
        step(1);  chk("rep_busy_e21", SEQ_BUSY, 1'b0);

        // Build cause 1011, then clear together with a watchdog pulse
        SYSRESETREQ = 1'b1; step(1); SYSRESETREQ = 1'b0;
        step(21);
        EXT_RESET_N = 1'b0; step(2); EXT_RESET_N = 1'b1;
        step(40);
        chk("pre_clr_cause", RESET_CAUSE, 4'b1011);
        chk("pre_clr_busy", SEQ_BUSY, 1'b0);
        CAUSE_CLR = 1'b1; WDT_RESET_REQ = 1'b1; step(1);
        CAUSE_CLR = 1'b0; WDT_RESET_REQ = 1'b0;
        chk("clrwdt_cause", RESET_CAUSE, 4'b0100);
        chk("clrwdt_bus", BUS_RESET_N, 1'b0);

        // Simultaneous watchdog and software sources
        step(25);
        chk("sim_pre_busy", SEQ_BUSY, 1'b0);
        CAUSE_CLR = 1'b1; step(1); CAUSE_CLR = 1'b0;
        WDT_RESET_REQ = 1'b1; SYSRESETREQ = 1'b1; step(1);
        WDT_RESET_REQ = 1'b0; SYSRESETREQ = 1'b0;
        chk("sim_cause", RESET_CAUSE, 4'b1100);
        chk("sim_bus_e0", BUS_RESET_N, 1'b0);
        step(15); chk("sim_bus_e15", BUS_RESET_N, 1'b0);
        step(1);  chk("sim_bus_e16", BUS_RESET_N, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter STRETCH_CYCLES, default 16, minimum number of cycles both reset outputs are held low after the last active request; legal range 2..255.
REQ-002 Parameter STAGE_GAP, default 4, number of cycles between BUS_RESET_N release and CPU_RESET_N release; legal range 1..255.
REQ-003 Parameter SYNC_STAGES, default 2, synchronizer depth for EXT_RESET_N; legal range 2..4.
REQ-004 CLK  input  1  system clock.
REQ-005 RESET  input  1  power-on reset, asynchronous, active-low.
REQ-006 EXT_RESET_N  input  1  external reset pin, asynchronous to CLK, active-low level.
REQ-007 WDT_RESET_REQ  input  1  watchdog reset request, CLK-synchronous, one-cycle pulse.
REQ-008 SYSRESETREQ  input  1  CPU software reset request, CLK-synchronous, level or pulse.
REQ-009 CAUSE_CLR  input  1  CLK-synchronous pulse; clears all sticky cause flags.
REQ-010 BUS_RESET_N  output  1  registered reset for the bus fabric and peripherals, active-low.
REQ-011 CPU_RESET_N  output  1  registered reset for the CPU, active-low.
REQ-012 RESET_CAUSE  output  4  sticky flags: [0] POR, [1] external pin, [2] watchdog, [3] software.
REQ-013 SEQ_BUSY  output  1  high in every state except RUN.

Function
REQ-014 EXT_RESET_N shall pass through a SYNC_STAGES-deep flop chain whose flops are cleared by RESET; the synchronized value is ext_n_s.
REQ-015 A request (req) shall be active in any cycle where ext_n_s==0, WDT_RESET_REQ==1, or SYSRESETREQ==1.
REQ-016 FSM states: ASSERT, REL_BUS, REL_CPU, RUN; an 8-bit down-counter provides the timing.
REQ-017 ASSERT: both outputs low; the counter loads STRETCH_CYCLES-1 on entry and on every cycle in which req is active; when the counter reaches 0 with req inactive, the FSM moves to REL_BUS.
REQ-018 REL_BUS: BUS_RESET_N high, CPU_RESET_N low; the counter loads STAGE_GAP-1 on entry; at 0 the FSM moves to REL_CPU.
REQ-019 REL_CPU: both outputs high for one cycle, then the FSM moves to RUN.
REQ-020 RUN: both outputs high; the FSM stays in RUN until req is active.
REQ-021 An active req in any state shall force ASSERT on the next clock edge, with both outputs low from that edge; there is no partial release.
REQ-022 Outputs shall be driven directly from state flops, with no combinational path from inputs to BUS_RESET_N or CPU_RESET_N.
REQ-023 Cause flag bits [1..3] shall be set in the cycle after their request source is active and shall stay set until CAUSE_CLR; sequencer-initiated resets shall not clear RESET_CAUSE.
REQ-024 If CAUSE_CLR and a source are active in the same cycle, the result shall be all flags cleared except that source's bit, which is set.
REQ-025 Simultaneous sources shall each set their own bit; ASSERT timing shall be identical whichever source triggered it.

Reset
REQ-026 While RESET is low: state ASSERT, counter STRETCH_CYCLES-1, BUS_RESET_N=0, CPU_RESET_N=0, RESET_CAUSE=4'b0001, SEQ_BUSY=1, synchronizer flops 0.
REQ-027 Assertion of RESET shall act asynchronously at any point, including mid-sequence; deassertion shall be sampled on CLK, and the stretch count starts at the first CLK edge after RESET goes high.

Structure
REQ-028 Package reset_sequencer_pkg shall hold the state enum (ASSERT, REL_BUS, REL_CPU, RUN) and the cause bit index constants CAUSE_POR=0, CAUSE_EXT=1, CAUSE_WDT=2, CAUSE_SW=3.
REQ-029 The EXT_RESET_N synchronizer shall be a separate sub-module named ext_pin_sync, parameterized by SYNC_STAGES; all other logic shall be flat in reset_sequencer.

Verification
REQ-030 POR: RESET high at cycle 0 with defaults -> BUS_RESET_N rises after edge 16, CPU_RESET_N rises 4 edges later, RESET_CAUSE=4'b0001, SEQ_BUSY low after edge 21.
REQ-031 WDT pulse in RUN -> both outputs low on the next edge, held 16 cycles, BUS before CPU with 4-cycle gap, RESET_CAUSE=4'b0101.
REQ-032 SYSRESETREQ held 10 cycles -> release of BUS_RESET_N occurs 16 cycles after its last high cycle; RESET_CAUSE[3]=1.
REQ-033 EXT_RESET_N low during REL_BUS -> BUS_RESET_N returns low within SYNC_STAGES+1 edges; CPU_RESET_N never goes high.
REQ-034 CAUSE_CLR in the same cycle as WDT_RESET_REQ, with RESET_CAUSE=4'b1011 -> RESET_CAUSE=4'b0100.
REQ-035 RESET pulsed low mid-REL_CPU -> outputs low immediately (asynchronously), RESET_CAUSE=4'b0001, and the full sequence repeats.
